// File: rtl/soc_bus_decoder.sv
// Address decoder, ready generator and read mux between the picorv32 memory port and NSLV slaves.
// Define SOC_BUS_TIMEOUT_EN to enable the wait-state watchdog for external-ready slaves.
module soc_bus_decoder #(
    parameter int              NSLV        = 6,
    parameter int              SEL_BITS    = 4,
    parameter logic [NSLV-1:0] FIXED_MASK  = 6'b101111,
    parameter int              TIMEOUT_CYC = 255,
    parameter logic [31:0]     ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                 clk_24,
    input  logic                 resetn,
    input  logic                 m_valid,
    input  logic [31:0]          m_addr,
    output logic                 m_ready,
    output logic [31:0]          m_rdata,
    output logic [NSLV-1:0]      s_sel,
    input  logic [NSLV*32-1:0]   s_rdata,
    input  logic [NSLV-1:0]      s_ready,
    input  logic                 err_clr,
    output logic                 bus_err,
    output logic [31:0]          err_addr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_resp;
    logic                 r_resp_err;
    logic                 w_resp_nxt;
    logic                 w_resp_err_nxt;
    logic                 w_err_set;
    logic                 w_wait_rdy;
    logic                 w_ready;
    logic                 r_bus_err;
    logic [31:0]          r_err_addr;
    logic [SEL_BITS-1:0]  w_idx;
    logic                 w_mapped;
    logic                 w_fixed;
    logic                 w_ext_rdy;
    logic                 w_timeout;
    logic [31:0]          w_slice;
    logic [NSLV-1:0]      w_sel;

    assign w_idx = m_addr[31:32-SEL_BITS];

    // Region lookup: an index with no matching slave leaves w_mapped low.
    always_comb begin
        w_mapped  = 1'b0;
        w_fixed   = 1'b0;
        w_ext_rdy = 1'b0;
        w_slice   = '0;
        w_sel     = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (w_idx == SEL_BITS'(i)) begin
                w_mapped  = 1'b1;
                w_fixed   = FIXED_MASK[i];
                w_ext_rdy = s_ready[i];
                w_slice   = s_rdata[32*i +: 32];
                w_sel[i]  = resetn && m_valid && (r_state != ST_DONE);
            end
        end
    end

`ifdef SOC_BUS_TIMEOUT_EN
    localparam int                CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_cnt;

    // Counts wait cycles in WAIT; cleared while idle and saturating at the limit.
    always_ff @(posedge clk_24) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_cnt <= '0;
        end else if ((r_state == ST_WAIT) && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_cnt == CNT_MAX);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_resp_nxt     = 1'b0;
        w_resp_err_nxt = 1'b0;
        w_err_set      = 1'b0;
        w_wait_rdy     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m_valid) begin
                    if (!w_mapped) begin
                        w_state_nxt    = ST_DONE;
                        w_resp_nxt     = 1'b1;
                        w_resp_err_nxt = 1'b1;
                        w_err_set      = 1'b1;
                    end else if (w_fixed) begin
                        w_state_nxt = ST_DONE;
                        w_resp_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A late s_ready still beats the watchdog in the same cycle.
                if (!m_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ext_rdy) begin
                    w_wait_rdy  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_timeout) begin
                    w_state_nxt    = ST_DONE;
                    w_resp_nxt     = 1'b1;
                    w_resp_err_nxt = 1'b1;
                    w_err_set      = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_24) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_resp     <= 1'b0;
            r_resp_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_resp     <= w_resp_nxt;
            r_resp_err <= w_resp_err_nxt;
        end
    end

    // A new error wins over a simultaneous clear and then refreshes err_addr.
    always_ff @(posedge clk_24) begin
        if (!resetn) begin
            r_bus_err  <= 1'b0;
            r_err_addr <= '0;
        end else if (w_err_set) begin
            r_bus_err <= 1'b1;
            if (!r_bus_err || err_clr) begin
                r_err_addr <= m_addr;
            end
        end else if (err_clr) begin
            r_bus_err <= 1'b0;
        end
    end

    assign w_ready  = resetn && (r_resp || w_wait_rdy);
    assign m_ready  = w_ready;
    assign m_rdata  = !w_ready ? 32'h0 : (r_resp_err ? ERR_DATA : w_slice);
    assign s_sel    = w_sel;
    assign bus_err  = r_bus_err;
    assign err_addr = r_err_addr;

endmodule

// File: tb/tb_soc_bus_decoder.sv
// Scoreboard bench for soc_bus_decoder: stimulus pushes expected responses, a monitor checks each m_ready.
module tb_soc_bus_decoder;

    localparam int          NSLV = 6;
    localparam int          TO   = 3;
    localparam logic [5:0]  MASK = 6'b101111;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
`ifdef SOC_BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk_24;
    logic              resetn;
    logic              m_valid;
    logic [31:0]       m_addr;
    logic              m_ready;
    logic [31:0]       m_rdata;
    logic [NSLV-1:0]   s_sel;
    logic [NSLV*32-1:0] s_rdata;
    logic [NSLV-1:0]   s_ready;
    logic              err_clr;
    logic              bus_err;
    logic [31:0]       err_addr;

    soc_bus_decoder #(
        .NSLV(NSLV), .SEL_BITS(4), .FIXED_MASK(MASK), .TIMEOUT_CYC(TO), .ERR_DATA(ERRD)
    ) dut (
        .clk_24(clk_24), .resetn(resetn), .m_valid(m_valid), .m_addr(m_addr),
        .m_ready(m_ready), .m_rdata(m_rdata), .s_sel(s_sel), .s_rdata(s_rdata),
        .s_ready(s_ready), .err_clr(err_clr), .bus_err(bus_err), .err_addr(err_addr)
    );

    typedef struct {
        int          rc;
        logic [31:0] rdata;
        logic        berr;
        logic [31:0] eaddr;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    bit          mdl_err;
    logic [31:0] mdl_addr;

    initial clk_24 = 1'b0;
    always #5 clk_24 = ~clk_24;
    always @(posedge clk_24) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: every m_ready pulse must match the oldest outstanding expectation.
    always @(negedge clk_24) begin
        if (mon_en) begin
            if (m_ready === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_ready", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_cycle", 32'(cyc), 32'(e.rc));
                    chk("resp_rdata", m_rdata, e.rdata);
                    chk("resp_bus_err", {31'b0, bus_err}, {31'b0, e.berr});
                    chk("resp_err_addr", err_addr, e.eaddr);
                end
            end else begin
                chk("idle_rdata", m_rdata, 32'h0);
            end
        end
    end

    task automatic rand_data();
        for (int i = 0; i < NSLV; i++) s_rdata[32*i +: 32] = $urandom;
    endtask

    // One CPU access. d = cycle (relative to m_valid rising) on which s_ready rises; 0 = never.
    task automatic do_txn(input logic [31:0] addr, input int d, input bit clr);
        int          idx, start, rc;
        bit          mapped, fixed, ext_ok, err;
        logic [31:0] rdata;
        logic [5:0]  exp_sel;
        idx    = int'(addr[31:28]);
        mapped = (idx < NSLV);
        fixed  = mapped && MASK[idx % NSLV];
        ext_ok = mapped && !fixed && (d > 0) && (!TO_EN || d <= TO + 1);
        @(posedge clk_24); #1;
        start   = cyc;
        m_addr  = addr;
        m_valid = 1'b1;
        err_clr = clr;
        if (!mapped) begin
            rc = start + 1; err = 1'b1;
        end else if (fixed) begin
            rc = start + 1; err = 1'b0;
        end else if (ext_ok) begin
            rc = start + d; err = 1'b0;
        end else begin
            rc = start + TO + 2; err = 1'b1;
        end
        rdata = err ? ERRD : s_rdata[32*(idx % NSLV) +: 32];
        if (clr && !(err && !mapped)) mdl_err = 1'b0;
        if (err) begin
            if (!mdl_err || clr) mdl_addr = addr;
            mdl_err = 1'b1;
        end
        q.push_back('{rc: rc, rdata: rdata, berr: mdl_err, eaddr: mdl_addr});
        exp_sel = mapped ? (6'b1 << idx) : 6'b0;
        @(negedge clk_24);
        chk("sel_first", {26'b0, s_sel}, {26'b0, exp_sel});
        while (cyc < rc) begin
            @(posedge clk_24); #1;
            err_clr = 1'b0;
            if (ext_ok && cyc == start + d) s_ready[idx] = 1'b1;
        end
        @(negedge clk_24);
        chk("sel_resp", {26'b0, s_sel}, {26'b0, (ext_ok ? exp_sel : 6'b0)});
        @(posedge clk_24); #1;
        m_valid = 1'b0;
        s_ready = '0;
    endtask

    task automatic do_clr();
        @(posedge clk_24); #1;
        err_clr = 1'b1;
        mdl_err = 1'b0;
        @(posedge clk_24); #1;
        err_clr = 1'b0;
        @(negedge clk_24);
        chk("clr_bus_err", {31'b0, bus_err}, {31'b0, mdl_err});
    endtask

    initial begin
        resetn  = 1'b0;
        m_valid = 1'b1;
        m_addr  = 32'h0;
        s_rdata = '0;
        s_ready = '0;
        err_clr = 1'b0;
        mdl_err = 1'b0;
        mdl_addr = 32'h0;
        repeat (3) @(posedge clk_24);
        @(negedge clk_24);
        chk("rst_ready", {31'b0, m_ready}, 32'h0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_sel", {26'b0, s_sel}, 32'h0);
        @(posedge clk_24); #1;
        resetn  = 1'b1;
        m_valid = 1'b0;
        mon_en  = 1'b1;

        rand_data();
        s_rdata[31:0] = 32'h1234_5678;
        do_txn(32'h0000_0040, 0, 1'b0);
        rand_data();
        do_txn(32'h4000_0100, 5, 1'b0);
        do_clr();
        do_txn(32'h7000_0010, 0, 1'b0);
        do_txn(32'h6000_0020, 0, 1'b0);
`ifdef SOC_BUS_TIMEOUT_EN
        do_clr();
        do_txn(32'h4000_0004, 0, 1'b0);
        rand_data();
        do_txn(32'h4000_0008, TO + 1, 1'b0);
`endif
        do_txn(32'h7000_0030, 0, 1'b1);
        do_clr();

        // CPU withdraws the request while waiting on an external slave.
        @(posedge clk_24); #1;
        m_addr = 32'h4000_0000; m_valid = 1'b1;
        @(negedge clk_24);
        chk("drop_sel_wait", {26'b0, s_sel}, 32'h10);
        repeat (2) @(posedge clk_24);
        #1 m_valid = 1'b0;
        @(negedge clk_24);
        chk("drop_sel_off", {26'b0, s_sel}, 32'h0);
        repeat (2) @(posedge clk_24);

        // Reset in the middle of a wait.
        do_txn(32'h7000_0044, 0, 1'b0);
        @(posedge clk_24); #1;
        m_addr = 32'h4000_0000; m_valid = 1'b1;
        repeat (2) @(posedge clk_24);
        #1 resetn = 1'b0;
        @(posedge clk_24);
        @(negedge clk_24);
        chk("wrst_ready", {31'b0, m_ready}, 32'h0);
        chk("wrst_bus_err", {31'b0, bus_err}, 32'h0);
        chk("wrst_err_addr", err_addr, 32'h0);
        chk("wrst_sel", {26'b0, s_sel}, 32'h0);
        @(posedge clk_24); #1;
        resetn = 1'b1; m_valid = 1'b0;
        mdl_err = 1'b0; mdl_addr = 32'h0;
        rand_data();
        do_txn(32'h1000_0000, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            rand_data();
            a = $urandom;
            a[31:28] = 4'($urandom_range(0, 7));
            do_txn(a, $urandom_range(1, 7), ($urandom_range(0, 7) == 0));
        end

        repeat (4) @(posedge clk_24);
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
